// File: rtl/truth_table_scanner_if.sv
// Bus between the truth-table scanner and its host / unit under test.
// master: the scanner (drives stimulus and results).
// slave : the host side (drives start and the unit's responses).
interface truth_table_scanner_if;
  logic        start;
  logic        x;
  logic        y;
  logic        w;
  logic        z;
  logic        s1;
  logic        s2;
  logic        busy;
  logic        done;
  logic [15:0] map1;
  logic [15:0] map2;
  logic        equal;
  logic [4:0]  mismatch_cnt;
  logic [3:0]  first_mis;
  logic [4:0]  zeros1;

  modport master (
    input  start, s1, s2,
    output x, y, w, z, busy, done, map1, map2,
    output equal, mismatch_cnt, first_mis, zeros1
  );

  modport slave (
    output start, s1, s2,
    input  x, y, w, z, busy, done, map1, map2,
    input  equal, mismatch_cnt, first_mis, zeros1
  );
endinterface

// File: rtl/truth_table_scanner.sv
// Truth-table scanner: sweeps all 16 {x,y,w,z} vectors, holds each for
// SETTLE cycles, samples s1/s2 on the last cycle of each hold and builds
// two 16-bit truth maps plus an equivalence summary.
module truth_table_scanner #(
  parameter int unsigned SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  truth_table_scanner_if.master  bus
);

  localparam int unsigned SETTLE_EFF = (SETTLE == 0) ? 1 : SETTLE;
  localparam int unsigned CNT_W      = 4;
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned MAP_W      = 16;
  localparam int unsigned SUM_W      = 5;
  localparam int unsigned LAST_IDX   = 15;

  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE_EFF - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(LAST_IDX);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_SCAN = 1'b1;

  logic [0:0]       r_state;
  logic [0:0]       w_state_nxt;
  logic [IDX_W-1:0] r_index;
  logic [IDX_W-1:0] w_index_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [MAP_W-1:0] r_map1;
  logic [MAP_W-1:0] w_map1_nxt;
  logic [MAP_W-1:0] r_map2;
  logic [MAP_W-1:0] w_map2_nxt;
  logic             r_busy;
  logic             w_busy_nxt;
  logic             r_done;
  logic             w_done_nxt;

  logic [MAP_W-1:0] w_diff;
  logic [SUM_W-1:0] w_mis_cnt;
  logic [SUM_W-1:0] w_ones1;
  logic [IDX_W-1:0] w_first_mis;

  // State and datapath registers; reset aborts any scan and clears the maps.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_index <= '0;
      r_cnt   <= '0;
      r_map1  <= '0;
      r_map2  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_index <= w_index_nxt;
      r_cnt   <= w_cnt_nxt;
      r_map1  <= w_map1_nxt;
      r_map2  <= w_map2_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Next-state logic: accept start in IDLE, then hold/sample each vector.
  always_comb begin
    w_state_nxt = r_state;
    w_index_nxt = r_index;
    w_cnt_nxt   = r_cnt;
    w_map1_nxt  = r_map1;
    w_map2_nxt  = r_map2;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_index_nxt = '0;
        if (bus.start) begin
          w_state_nxt = S_SCAN;
          w_cnt_nxt   = CNT_RELOAD;
          w_map1_nxt  = '0;
          w_map2_nxt  = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      S_SCAN: begin
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end else begin
          // Last cycle of the hold: capture responses for this vector.
          w_map1_nxt[r_index] = bus.s1;
          w_map2_nxt[r_index] = bus.s2;
          if (r_index == IDX_LAST) begin
            w_state_nxt = S_IDLE;
            w_index_nxt = '0;
            w_cnt_nxt   = '0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
          end else begin
            w_index_nxt = r_index + IDX_W'(1);
            w_cnt_nxt   = CNT_RELOAD;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_index_nxt = '0;
        w_cnt_nxt   = '0;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  // Map summaries: mismatch popcount, lowest mismatching index, ones in map1.
  always_comb begin
    w_diff      = r_map1 ^ r_map2;
    w_mis_cnt   = '0;
    w_ones1     = '0;
    w_first_mis = '0;
    for (int i = MAP_W - 1; i >= 0; i--) begin
      w_mis_cnt = w_mis_cnt + SUM_W'(w_diff[i]);
      w_ones1   = w_ones1 + SUM_W'(r_map1[i]);
      if (w_diff[i]) begin
        w_first_mis = IDX_W'(i);
      end
    end
  end

  assign bus.x            = r_index[3];
  assign bus.y            = r_index[2];
  assign bus.w            = r_index[1];
  assign bus.z            = r_index[0];
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.map1         = r_map1;
  assign bus.map2         = r_map2;
  assign bus.equal        = (w_mis_cnt == '0);
  assign bus.mismatch_cnt = w_mis_cnt;
  assign bus.first_mis    = w_first_mis;
  assign bus.zeros1       = SUM_W'(MAP_W) - w_ones1;

endmodule

// File: doc/truth_table_scanner.md
Name: truth_table_scanner

Overview:
- Sequential stimulus/capture engine: the driving end of a 4-input, 2-output combinational evaluator.
- Sweeps all 16 input vectors {x,y,w,z} in ascending order, samples the two responses (s1 = unsimplified form, s2 = simplified form) and builds a 16-bit truth map for each.
- Reports an equivalence summary between the two maps.
- Replaces hand-written #1 stimulus lists with a synthesizable scan that hardware can run against a unit under test.

Parameters:
SETTLE, 1, cycles each vector is held before its response is sampled; legal 1..15; a value of 0 is treated as 1.

Ports:
clk  input  1  clock, rising-edge active
rst  input  1  synchronous reset, active-high
start  input  1  request a scan; sampled only while idle
x  output  1  stimulus bit 3 (MSB of vector index)
y  output  1  stimulus bit 2
w  output  1  stimulus bit 1
z  output  1  stimulus bit 0 (LSB of vector index)
s1  input  1  response 1 from the unit under test
s2  input  1  response 2 from the unit under test
busy  output  1  scan in progress
done  output  1  one-cycle pulse: scan complete, results valid
map1  output  16  captured s1; bit k = response to vector index k
map2  output  16  captured s2; bit k = response to vector index k
equal  output  1  map1 == map2
mismatch_cnt  output  5  popcount(map1 ^ map2), 0..16
first_mis  output  4  lowest k with map1[k] != map2[k]; 0 when equal
zeros1  output  5  number of 0 bits in map1 (maxterm count), 0..16

Behaviour:
- Reset (rst high at a clock edge):
  - state IDLE, index 0, settle counter 0.
  - x/y/w/z = 0, busy = 0, done = 0, map1 = map2 = 0.
  - Summaries follow the maps: equal = 1, mismatch_cnt = 0, first_mis = 0, zeros1 = 16.
  - rst has priority over everything. Reset mid-scan aborts the scan with no done pulse and clears the maps.
- States are IDLE, SCAN.
- IDLE:
  - {x,y,w,z} = 0.
  - start = 1 at edge E0 → SCAN, index = 0, map1 = map2 = 0, busy = 1 from E0.
- SCAN:
  - {x,y,w,z} = index, registered.
  - Vector k is presented from edge E0 + k*SETTLE.
  - Its responses are sampled into map1[k] / map2[k] at edge E0 + (k+1)*SETTLE, using s1/s2 as seen just before that edge.
  - On the sample edge, if k < 15: index = k+1 and the settle counter reloads.
  - On the sample edge, if k = 15: → IDLE, busy = 0, done = 1 for exactly one cycle, {x,y,w,z} = 0.
- Latency: done is high in the cycle after edge E0 + 16*SETTLE. busy is high for exactly 16*SETTLE cycles.
- start is ignored while busy. A start seen in the done cycle (state already IDLE) is accepted, so back-to-back scans have no gap beyond the done cycle.
- map1/map2 hold their values after done until the next accepted start or rst.
- Summary outputs are combinational from map1/map2. They are only meaningful when not busy, and change during a scan as bits fill.
- first_mis is a priority encode, lowest index wins.
- zeros1 = 16 - popcount(map1).
- No X-handling is required; the bench drives known response values.

Test Plan:
1. SETTLE=1, s1=s2=0, pulse start → busy for 16 cycles, done in the 17th cycle after the start edge; map1=map2=16'h0000, equal=1, mismatch_cnt=0, zeros1=16.
2. SETTLE=1, s1=s2=z → map1=map2=16'hAAAA, zeros1=8, equal=1, first_mis=0; x/y/w/z observed stepping 0000..1111, then back to 0000 in the done cycle.
3. SETTLE=2, s1=1, s2=0 at vector indices 5 and 9 and 1 elsewhere → map1=16'hFFFF, map2=16'hFDDF, mismatch_cnt=2, first_mis=5, equal=0, zeros1=0.
4. rst asserted while vector 6 is driven → next cycle busy=0, maps=0, xywz=0, no done pulse; a new start then produces a complete scan matching scenario 2.
5. SETTLE=3, start held high continuously, extra start pulses during busy → one done every 49 cycles (48 busy + 1 done/IDLE), never an early done or restart mid-scan.
6. s1 = z delayed by one register stage: SETTLE=2 → map1=16'hAAAA; SETTLE=1 → map1=16'h5554, proving sampling occurs at the last cycle of each hold.
